data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the processor's load/store path (MemRead, MemWrite, busy) and a slow backing data memory with a req/ack handshake.
- Read hits return data in the same cycle with busy low.
- Read misses and all writes stall the processor via busy until the backing memory acknowledges.
- Also keeps saturating hit/miss counters for the debug view.

---
 rtl/data_cache_if.sv | 29 ++
 rtl/data_cache.sv | 117 +++++++++++
 tb/tb_data_cache.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Processor load/store bus and backing-memory req/ack bus seen by data_cache.
interface data_cache_if #(
   parameter int NBITS = 8
);
   logic [NBITS-1:0] addr;
   logic [NBITS-1:0] wdata;
   logic             MemRead;
   logic             MemWrite;
   logic [NBITS-1:0] rdata;
   logic             busy;
   logic [NBITS-1:0] mem_addr;
   logic [NBITS-1:0] mem_wdata;
   logic             mem_read;
   logic             mem_write;
   logic [NBITS-1:0] mem_rdata;
   logic             mem_ack;

   // Environment side: processor datapath plus backing memory.
   modport master (
      output addr, wdata, MemRead, MemWrite, mem_rdata, mem_ack,
      input  rdata, busy, mem_addr, mem_wdata, mem_read, mem_write
   );

   // Cache side.
   modport slave (
      input  addr, wdata, MemRead, MemWrite, mem_rdata, mem_ack,
      output rdata, busy, mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines, a req/ack backing memory port and saturating hit/miss counters.
module data_cache #(
   parameter int NBITS  = 8,
   parameter int NLINES = 8,
   parameter int NCNT   = 8
) (
   input  logic            clock,
   input  logic            reset,
   data_cache_if.slave     bus,
   output logic [NCNT-1:0] hits,
   output logic [NCNT-1:0] misses
);
   localparam int IDXW = $clog2(NLINES);
   localparam int TAGW = NBITS - IDXW;
   localparam logic [NCNT-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t            state_q, state_d;
   logic [NLINES-1:0] valid_q, valid_d;
   logic [TAGW-1:0]   tag_q   [NLINES];
   logic [TAGW-1:0]   tag_d   [NLINES];
   logic [NBITS-1:0]  data_q  [NLINES];
   logic [NBITS-1:0]  data_d  [NLINES];
   logic [NCNT-1:0]   hits_q, hits_d;
   logic [NCNT-1:0]   misses_q, misses_d;

   logic [IDXW-1:0]   idx;
   logic [TAGW-1:0]   tag_in;
   logic              hit;

   assign idx    = bus.addr[IDXW-1:0];
   assign tag_in = bus.addr[NBITS-1:IDXW];
   assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

   // Next-state, line update and counter logic.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      data_d   = data_q;
      hits_d   = hits_q;
      misses_d = misses_q;
      case (state_q)
         IDLE: begin
            if (bus.MemWrite) begin
               state_d = WRITE;
            end else if (bus.MemRead) begin
               if (hit) begin
                  hits_d = (hits_q == CNT_MAX) ? hits_q : hits_q + 1'b1;
               end else begin
                  misses_d = (misses_q == CNT_MAX) ? misses_q : misses_q + 1'b1;
                  state_d  = FILL;
               end
            end
         end
         FILL: begin
            if (bus.mem_ack) begin
               valid_d[idx] = 1'b1;
               tag_d[idx]   = tag_in;
               data_d[idx]  = bus.mem_rdata;
               state_d      = IDLE;
            end
         end
         WRITE: begin
            if (bus.mem_ack) begin
               if (hit) begin
                  data_d[idx] = bus.wdata;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset aborts any outstanding request; line data and tags are kept,
      // only the valid bits are cleared so no stale line can hit.
      if (reset) begin
         state_d  = IDLE;
         valid_d  = '0;
         tag_d    = tag_q;
         data_d   = data_q;
         hits_d   = '0;
         misses_d = '0;
      end
   end

   // State, storage and counter registers.
   always_ff @(posedge clock) begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
   end

   // Processor and memory-side outputs; requests decode directly from state.
   always_comb begin
      bus.busy = 1'b0;
      if (!reset) begin
         if (state_q == IDLE) begin
            bus.busy = bus.MemWrite || (bus.MemRead && !hit);
         end else begin
            bus.busy = 1'b1;
         end
      end
      bus.rdata     = data_q[idx];
      bus.mem_read  = (state_q == FILL);
      bus.mem_write = (state_q == WRITE);
      bus.mem_addr  = bus.addr;
      bus.mem_wdata = bus.wdata;
   end

   assign hits   = hits_q;
   assign misses = misses_q;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: stimulus pushes expected load data into a
// scoreboard queue, a monitor pops it on every served read.
module tb_data_cache;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   data_cache_if #(.NBITS(8)) bif ();
   data_cache_if #(.NBITS(8)) bif2 ();

   logic [7:0] hits, misses;
   logic [1:0] hits2, misses2;

   data_cache #(.NBITS(8), .NLINES(8), .NCNT(8)) u_dut (
      .clock(clock), .reset(reset), .bus(bif.slave), .hits(hits), .misses(misses)
   );

   // Shadow instance with 2-bit counters, driven by the same stimulus.
   data_cache #(.NBITS(8), .NLINES(8), .NCNT(2)) u_dut_sat (
      .clock(clock), .reset(reset), .bus(bif2.slave), .hits(hits2), .misses(misses2)
   );

   assign bif2.addr      = bif.addr;
   assign bif2.wdata     = bif.wdata;
   assign bif2.MemRead   = bif.MemRead;
   assign bif2.MemWrite  = bif.MemWrite;
   assign bif2.mem_rdata = bif.mem_rdata;
   assign bif2.mem_ack   = bif.mem_ack;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   // Scoreboard monitor: a load is served when MemRead is up and busy is low.
   always @(negedge clock) begin
      if (reset === 1'b0 && bif.MemRead === 1'b1 && bif.MemWrite === 1'b0 && bif.busy === 1'b0) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected_read: got %0h expected none", bif.rdata);
         end else begin
            check("sb_rdata", bif.rdata, exp_q.pop_front());
         end
      end
   end

   task automatic read_miss(input logic [7:0] a, input logic [7:0] d, input int ack_wait,
                            input logic [7:0] em, input logic [7:0] eh);
      exp_q.push_back(d);
      bif.addr = a;
      bif.MemRead = 1'b1;
      mid();
      check("miss_busy", bif.busy, 1);
      check("miss_no_req_yet", bif.mem_read, 0);
      check("misses_pre", misses, em - 8'd1);
      cyc();
      for (int i = 0; i < ack_wait; i++) begin
         mid();
         check("fill_mem_read", bif.mem_read, 1);
         check("fill_mem_addr", bif.mem_addr, a);
         check("fill_busy", bif.busy, 1);
         cyc();
      end
      bif.mem_rdata = d;
      bif.mem_ack = 1'b1;
      mid();
      check("fill_ack_mem_read", bif.mem_read, 1);
      check("fill_ack_busy", bif.busy, 1);
      cyc();
      bif.mem_ack = 1'b0;
      bif.mem_rdata = 8'h00;
      mid();
      check("fill_done_busy", bif.busy, 0);
      check("fill_done_mem_read", bif.mem_read, 0);
      check("misses_post", misses, em);
      check("hits_served", hits, eh);
      cyc();
      bif.MemRead = 1'b0;
   endtask

   task automatic read_hit(input logic [7:0] a, input logic [7:0] d, input logic [7:0] eh);
      exp_q.push_back(d);
      bif.addr = a;
      bif.MemRead = 1'b1;
      mid();
      check("hit_busy", bif.busy, 0);
      check("hit_mem_read", bif.mem_read, 0);
      check("hit_hits", hits, eh);
      cyc();
      bif.MemRead = 1'b0;
   endtask

   task automatic write(input logic [7:0] a, input logic [7:0] d, input int ack_wait,
                        input logic with_read);
      bif.addr = a;
      bif.wdata = d;
      bif.MemWrite = 1'b1;
      bif.MemRead = with_read;
      mid();
      check("wr_busy", bif.busy, 1);
      cyc();
      for (int i = 0; i < ack_wait; i++) begin
         mid();
         check("wr_mem_write", bif.mem_write, 1);
         check("wr_mem_read", bif.mem_read, 0);
         check("wr_mem_addr", bif.mem_addr, a);
         check("wr_mem_wdata", bif.mem_wdata, d);
         cyc();
      end
      bif.mem_ack = 1'b1;
      mid();
      check("wr_ack_busy", bif.busy, 1);
      check("wr_ack_mem_write", bif.mem_write, 1);
      check("wr_ack_mem_read", bif.mem_read, 0);
      check("wr_ack_mem_wdata", bif.mem_wdata, d);
      cyc();
      bif.mem_ack = 1'b0;
      bif.MemWrite = 1'b0;
      bif.MemRead = 1'b0;
      mid();
      check("wr_done_busy", bif.busy, 0);
      check("wr_done_mem_write", bif.mem_write, 0);
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bif.addr = 8'h00;
      bif.wdata = 8'h00;
      bif.MemRead = 1'b0;
      bif.MemWrite = 1'b0;
      bif.mem_rdata = 8'h00;
      bif.mem_ack = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      mid();
      check("rst_busy", bif.busy, 0);
      check("rst_mem_read", bif.mem_read, 0);
      check("rst_mem_write", bif.mem_write, 0);
      check("rst_hits", hits, 0);
      check("rst_misses", misses, 0);
      cyc();

      // 1: cold miss on 0x13, ack in third FILL cycle.
      read_miss(8'h13, 8'hA5, 2, 8'd1, 8'd0);
      // 2: hit, then conflicting tag on index 3, then 0x13 evicted.
      read_hit(8'h13, 8'hA5, 8'd1);
      read_miss(8'h0B, 8'h3C, 0, 8'd2, 8'd2);
      read_miss(8'h13, 8'hA5, 1, 8'd3, 8'd3);
      read_miss(8'h0B, 8'h3C, 0, 8'd4, 8'd4);
      // 3: write-through to cached line updates it; uncached store does not allocate.
      write(8'h0B, 8'h77, 1, 1'b0);
      read_hit(8'h0B, 8'h77, 8'd5);
      write(8'h21, 8'h55, 0, 1'b0);
      read_miss(8'h21, 8'h55, 0, 8'd5, 8'd6);
      // 4: MemWrite wins over MemRead; counters untouched.
      write(8'h05, 8'h99, 1, 1'b1);
      mid();
      check("both_hits", hits, 8'd7);
      check("both_misses", misses, 8'd5);
      check("sat_hits_pre", hits2, 2'd3);
      check("sat_misses_pre", misses2, 2'd3);
      cyc();
      read_miss(8'h05, 8'h99, 0, 8'd6, 8'd7);

      // 5: reset in the middle of a fill, then a late ack.
      bif.addr = 8'h1C;
      bif.MemRead = 1'b1;
      cyc();
      mid();
      check("abort_mem_read", bif.mem_read, 1);
      cyc();
      reset = 1'b1;
      mid();
      check("abort_busy_in_reset", bif.busy, 0);
      cyc();
      reset = 1'b0;
      bif.MemRead = 1'b0;
      mid();
      check("abort_mem_read_after", bif.mem_read, 0);
      check("abort_busy_after", bif.busy, 0);
      check("abort_hits", hits, 0);
      check("abort_misses", misses, 0);
      cyc();
      bif.mem_rdata = 8'hDD;
      bif.mem_ack = 1'b1;
      cyc();
      bif.mem_ack = 1'b0;
      bif.mem_rdata = 8'h00;
      mid();
      check("late_ack_mem_read", bif.mem_read, 0);
      check("late_ack_mem_write", bif.mem_write, 0);
      check("late_ack_busy", bif.busy, 0);
      cyc();
      read_miss(8'h0B, 8'h77, 0, 8'd1, 8'd0);
      read_miss(8'h1C, 8'hEE, 0, 8'd2, 8'd1);

      // 6: saturating counters in the 2-bit instance, idle ack ignored.
      for (int i = 0; i < 5; i++) begin
         read_hit(8'h1C, 8'hEE, 8'd2 + 8'(i));
      end
      mid();
      check("sat_hits", hits2, 2'd3);
      check("sat_misses", misses2, 2'd2);
      check("wide_hits", hits, 8'd7);
      cyc();
      bif.addr = 8'h1C;
      bif.mem_rdata = 8'h11;
      bif.mem_ack = 1'b1;
      cyc();
      bif.mem_ack = 1'b0;
      bif.mem_rdata = 8'h00;
      mid();
      check("idle_ack_mem_read", bif.mem_read, 0);
      check("idle_ack_mem_write", bif.mem_write, 0);
      check("idle_ack_hits", hits, 8'd7);
      check("idle_ack_misses", misses, 8'd2);
      cyc();
      read_hit(8'h1C, 8'hEE, 8'd7);

      mid();
      check("sb_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
